tl_client_arbiter: RTL
======================

# tl_client_arbiter

Two-to-one TileLink-UL client arbiter that lets two master blocks (for example a Verilog accelerator's client port and a DMA engine) share one TL-UL client port into the system bus. Requests on channel A are merged round-robin with grant locking. Responses on channel D are routed back by a requester-index bit prepended to the source ID. Per-requester in-flight counters cap outstanding transactions.

## Interface
- ADDR_BITS, 32, address width on all ports
- DATA_BITS, 64, data width; mask width DATA_BITS/8
- SOURCE_BITS, 4, source width on each input port; the output port uses SOURCE_BITS+1
- SINK_BITS, 1, sink width on all ports
- SIZE_BITS, 3, size width on all ports
- MAX_INFLIGHT, 4, maximum outstanding A requests per requester (1..15)

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- tl_inN_a_ready  out  1  A ready to requester N (N = 0, 1)
- tl_inN_a_valid  in  1  A valid from requester N
- tl_inN_a_bits_{opcode,param,size,source,address,mask,data,corrupt}  in  3/3/SIZE_BITS/SOURCE_BITS/ADDR_BITS/DATA_BITS/8/DATA_BITS/1  A payload from requester N
- tl_inN_d_ready  in  1  D ready from requester N
- tl_inN_d_valid  out  1  D valid to requester N
- tl_inN_d_bits_{opcode,param,size,source,sink,denied,data,corrupt}  out  3/2/SIZE_BITS/SOURCE_BITS/SINK_BITS/1/DATA_BITS/1  D payload to requester N
- tl_out_a_ready  in  1  A ready from bus
- tl_out_a_valid  out  1  merged A valid
- tl_out_a_bits_*  out  as above; source is SOURCE_BITS+1  merged A payload
- tl_out_d_ready  out  1  D ready to bus
- tl_out_d_valid  in  1  D valid from bus
- tl_out_d_bits_*  in  as above; source is SOURCE_BITS+1  D payload from bus

## Operation
- **Eligibility:** requester N is eligible when tl_inN_a_valid=1 and inflight[N] < MAX_INFLIGHT.
- **Grant:**
  - If lock=1, grant is the locked index.
  - Otherwise, if both requesters are eligible, grant goes to the one selected by the priority pointer `prio`.
  - Otherwise, grant goes to the single eligible requester.
  - If none is eligible, tl_out_a_valid=0.
- **A forwarding:** tl_out_a_valid = the granted requester's valid. The payload is muxed from the granted requester, with tl_out_a_bits_source = {grant, tl_inN_a_bits_source}. tl_inN_a_ready = tl_out_a_ready & (grant==N) & eligible or locked. The non-granted requester sees ready=0.
- **Lock:** set when tl_out_a_valid=1 and tl_out_a_ready=0, holding the current grant. Cleared on the A fire. This guarantees a presented request is never withdrawn or swapped.
- **Priority pointer:** on every A fire, prio <= ~grant. Idle cycles leave it unchanged.
- **D routing:** idx = tl_out_d_bits_source[SOURCE_BITS]. tl_in{idx}_d_valid = tl_out_d_valid; the other requester sees 0. The payload is broadcast to both requesters with the source MSB stripped. tl_out_d_ready = tl_in{idx}_d_ready.
- **In-flight counters:** width $clog2(MAX_INFLIGHT+1).
  - +1 on an A fire for N; −1 on a D fire for N; unchanged when both happen in the same cycle.
  - Saturation never occurs because of the eligibility gate.
  - A D fire with a counter at 0 is a protocol error. The counter holds at 0, and a simulation-only assertion fires.
- **Reset values:** prio=0, lock=0, inflight[0]=inflight[1]=0. Outputs are combinational from these and the inputs, so with idle inputs every valid/ready output is 0.

## Timing
- A and D paths are fully combinational pass-through: zero added latency and no bubbles. Back-to-back fires are allowed every cycle.
- Counters, prio and lock update on the rising clock edge following the fire.
- A request that reaches the limit in cycle t (fire makes inflight = MAX_INFLIGHT) is ineligible from t+1 until a D fire for it.
- A D fire in cycle t frees a slot; the requester is eligible in t+1.
- Reset asserted mid-transaction clears the counters and lock at the next edge. Outstanding responses arriving after reset still route by source MSB, and their counter decrement is suppressed at 0.

## Structure
- Package tl_arb_pkg holds the TL-UL opcode constants (Get=4, PutFull=0, PutPartial=1, AccessAck=0, AccessAckData=1) and a function for the counter width.
- Sub-module tl_inflight_counter: up/down counter with limit flag and underflow assertion, instantiated twice.
- Arbiter, lock and D router live in the top module.

## Test plan
- **Alternation:** both requesters valid every cycle, bus ready=1, responses immediate → A grants alternate 0,1,0,1. Out sources are 0x10|s1 for requester 1 and 0x0s for requester 0.
- **Lock:** requester 0 presents a Get, bus a_ready=0 for 3 cycles, then requester 1 also asserts valid → out A stays requester 0's payload unchanged until the fire. Requester 1 fires next.
- **Limit:** MAX_INFLIGHT=4, requester 0 issues 4 Gets with no responses → the 5th is blocked (a_ready=0) while requester 1 is still granted. One AccessAckData to requester 0 lets it fire on the following cycle.
- **D routing:** D source 0x13 → tl_in1_d_valid=1 with source 0x3 and tl_in0_d_valid=0. tl_in1_d_ready=0 stalls tl_out_d_ready.
- **Simultaneous:** A fire and D fire for requester 1 in the same cycle → inflight[1] is unchanged.
- **Reset mid-run:** inflight=2 and lock=1, assert reset for 1 cycle → all counters 0, lock 0, prio 0; the next grant goes to requester 0 when both are valid.

Source files
------------

// File: rtl/tl_arb_pkg.sv
// Shared constants, types and helpers for the two-to-one TL-UL client arbiter.
package tl_arb_pkg;

   localparam logic [2:0] TL_A_PUT_FULL        = 3'd0;
   localparam logic [2:0] TL_A_PUT_PARTIAL     = 3'd1;
   localparam logic [2:0] TL_A_GET             = 3'd4;
   localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
   localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

   typedef enum logic {
      ARB_OPEN,
      ARB_LOCKED
   } arb_state_e;

   // Width of a counter that must hold 0..max_inflight inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_inflight);
      return $clog2(max_inflight + 1);
   endfunction

endpackage

// File: rtl/tl_inflight_counter.sv
// Per-requester outstanding-transaction counter with a limit flag.
module tl_inflight_counter
   import tl_arb_pkg::*;
#(
   parameter int unsigned MAX_INFLIGHT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic inc,
   input  logic dec,
   output logic at_limit_c
);

   localparam int unsigned CNT_BITS = cnt_width(MAX_INFLIGHT);

   logic [CNT_BITS-1:0] count_q;

   // Simultaneous request and response cancel; a response at zero is dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else if (inc && !dec) begin
         count_q <= count_q + CNT_BITS'(1);
      end else if (dec && !inc && count_q != '0) begin
         count_q <= count_q - CNT_BITS'(1);
      end
   end

   assign at_limit_c = (count_q == CNT_BITS'(MAX_INFLIGHT));

`ifndef SYNTHESIS
   underflow_a : assert property (@(posedge clock) disable iff (reset)
      !(dec && !inc && count_q == '0))
      else $error("tl_inflight_counter: D response with no request in flight");
`endif

endmodule

// File: rtl/tl_client_arbiter.sv
// Two-to-one TL-UL client arbiter: round-robin A merge with grant lock,
// source-MSB D routing and per-requester in-flight limits.
module tl_client_arbiter
   import tl_arb_pkg::*;
#(
   parameter int unsigned ADDR_BITS    = 32,
   parameter int unsigned DATA_BITS    = 64,
   parameter int unsigned SOURCE_BITS  = 4,
   parameter int unsigned SINK_BITS    = 1,
   parameter int unsigned SIZE_BITS    = 3,
   parameter int unsigned MAX_INFLIGHT = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   // requester 0
   output logic                     tl_in0_a_ready,
   input  logic                     tl_in0_a_valid,
   input  logic [2:0]               tl_in0_a_bits_opcode,
   input  logic [2:0]               tl_in0_a_bits_param,
   input  logic [SIZE_BITS-1:0]     tl_in0_a_bits_size,
   input  logic [SOURCE_BITS-1:0]   tl_in0_a_bits_source,
   input  logic [ADDR_BITS-1:0]     tl_in0_a_bits_address,
   input  logic [DATA_BITS/8-1:0]   tl_in0_a_bits_mask,
   input  logic [DATA_BITS-1:0]     tl_in0_a_bits_data,
   input  logic                     tl_in0_a_bits_corrupt,
   input  logic                     tl_in0_d_ready,
   output logic                     tl_in0_d_valid,
   output logic [2:0]               tl_in0_d_bits_opcode,
   output logic [1:0]               tl_in0_d_bits_param,
   output logic [SIZE_BITS-1:0]     tl_in0_d_bits_size,
   output logic [SOURCE_BITS-1:0]   tl_in0_d_bits_source,
   output logic [SINK_BITS-1:0]     tl_in0_d_bits_sink,
   output logic                     tl_in0_d_bits_denied,
   output logic [DATA_BITS-1:0]     tl_in0_d_bits_data,
   output logic                     tl_in0_d_bits_corrupt,
   // requester 1
   output logic                     tl_in1_a_ready,
   input  logic                     tl_in1_a_valid,
   input  logic [2:0]               tl_in1_a_bits_opcode,
   input  logic [2:0]               tl_in1_a_bits_param,
   input  logic [SIZE_BITS-1:0]     tl_in1_a_bits_size,
   input  logic [SOURCE_BITS-1:0]   tl_in1_a_bits_source,
   input  logic [ADDR_BITS-1:0]     tl_in1_a_bits_address,
   input  logic [DATA_BITS/8-1:0]   tl_in1_a_bits_mask,
   input  logic [DATA_BITS-1:0]     tl_in1_a_bits_data,
   input  logic                     tl_in1_a_bits_corrupt,
   input  logic                     tl_in1_d_ready,
   output logic                     tl_in1_d_valid,
   output logic [2:0]               tl_in1_d_bits_opcode,
   output logic [1:0]               tl_in1_d_bits_param,
   output logic [SIZE_BITS-1:0]     tl_in1_d_bits_size,
   output logic [SOURCE_BITS-1:0]   tl_in1_d_bits_source,
   output logic [SINK_BITS-1:0]     tl_in1_d_bits_sink,
   output logic                     tl_in1_d_bits_denied,
   output logic [DATA_BITS-1:0]     tl_in1_d_bits_data,
   output logic                     tl_in1_d_bits_corrupt,
   // system bus
   input  logic                     tl_out_a_ready,
   output logic                     tl_out_a_valid,
   output logic [2:0]               tl_out_a_bits_opcode,
   output logic [2:0]               tl_out_a_bits_param,
   output logic [SIZE_BITS-1:0]     tl_out_a_bits_size,
   output logic [SOURCE_BITS:0]     tl_out_a_bits_source,
   output logic [ADDR_BITS-1:0]     tl_out_a_bits_address,
   output logic [DATA_BITS/8-1:0]   tl_out_a_bits_mask,
   output logic [DATA_BITS-1:0]     tl_out_a_bits_data,
   output logic                     tl_out_a_bits_corrupt,
   output logic                     tl_out_d_ready,
   input  logic                     tl_out_d_valid,
   input  logic [2:0]               tl_out_d_bits_opcode,
   input  logic [1:0]               tl_out_d_bits_param,
   input  logic [SIZE_BITS-1:0]     tl_out_d_bits_size,
   input  logic [SOURCE_BITS:0]     tl_out_d_bits_source,
   input  logic [SINK_BITS-1:0]     tl_out_d_bits_sink,
   input  logic                     tl_out_d_bits_denied,
   input  logic [DATA_BITS-1:0]     tl_out_d_bits_data,
   input  logic                     tl_out_d_bits_corrupt
);

   arb_state_e state_q, state_d;
   logic       lock_idx_q, lock_idx_d;
   logic       prio_q, prio_d;
   logic       grant, sel_ok, a_fire, d_idx;
   logic [1:0] eligible, at_limit, a_fire_n, d_fire_n;

   assign eligible = {tl_in1_a_valid & ~at_limit[1], tl_in0_a_valid & ~at_limit[0]};

   // A locked grant wins; otherwise the priority pointer breaks ties.
   always_comb begin
      grant  = 1'b0;
      sel_ok = 1'b0;
      if (state_q == ARB_LOCKED) begin
         grant  = lock_idx_q;
         sel_ok = 1'b1;
      end else if (&eligible) begin
         grant  = prio_q;
         sel_ok = 1'b1;
      end else if (eligible[1]) begin
         grant  = 1'b1;
         sel_ok = 1'b1;
      end else if (eligible[0]) begin
         sel_ok = 1'b1;
      end
   end

   assign tl_out_a_valid        = sel_ok & (grant ? tl_in1_a_valid : tl_in0_a_valid);
   assign tl_in0_a_ready        = tl_out_a_ready & sel_ok & ~grant;
   assign tl_in1_a_ready        = tl_out_a_ready & sel_ok & grant;
   assign tl_out_a_bits_opcode  = grant ? tl_in1_a_bits_opcode  : tl_in0_a_bits_opcode;
   assign tl_out_a_bits_param   = grant ? tl_in1_a_bits_param   : tl_in0_a_bits_param;
   assign tl_out_a_bits_size    = grant ? tl_in1_a_bits_size    : tl_in0_a_bits_size;
   assign tl_out_a_bits_source  = {grant, grant ? tl_in1_a_bits_source : tl_in0_a_bits_source};
   assign tl_out_a_bits_address = grant ? tl_in1_a_bits_address : tl_in0_a_bits_address;
   assign tl_out_a_bits_mask    = grant ? tl_in1_a_bits_mask    : tl_in0_a_bits_mask;
   assign tl_out_a_bits_data    = grant ? tl_in1_a_bits_data    : tl_in0_a_bits_data;
   assign tl_out_a_bits_corrupt = grant ? tl_in1_a_bits_corrupt : tl_in0_a_bits_corrupt;

   assign a_fire   = tl_out_a_valid & tl_out_a_ready;
   assign a_fire_n = {a_fire & grant, a_fire & ~grant};

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ARB_OPEN;
         lock_idx_q <= 1'b0;
         prio_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_idx_q <= lock_idx_d;
         prio_q     <= prio_d;
      end
   end

   // A stalled request pins the grant until it fires.
   always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      prio_d     = prio_q;
      if (a_fire) begin
         state_d = ARB_OPEN;
         prio_d  = ~grant;
      end else if (tl_out_a_valid) begin
         state_d    = ARB_LOCKED;
         lock_idx_d = grant;
      end
   end

   // Responses steer on the prepended requester bit; payload is broadcast.
   assign d_idx          = tl_out_d_bits_source[SOURCE_BITS];
   assign tl_in0_d_valid = tl_out_d_valid & ~d_idx;
   assign tl_in1_d_valid = tl_out_d_valid & d_idx;
   assign tl_out_d_ready = d_idx ? tl_in1_d_ready : tl_in0_d_ready;
   assign d_fire_n       = {tl_in1_d_valid & tl_in1_d_ready, tl_in0_d_valid & tl_in0_d_ready};

   assign tl_in0_d_bits_opcode  = tl_out_d_bits_opcode;
   assign tl_in0_d_bits_param   = tl_out_d_bits_param;
   assign tl_in0_d_bits_size    = tl_out_d_bits_size;
   assign tl_in0_d_bits_source  = tl_out_d_bits_source[SOURCE_BITS-1:0];
   assign tl_in0_d_bits_sink    = tl_out_d_bits_sink;
   assign tl_in0_d_bits_denied  = tl_out_d_bits_denied;
   assign tl_in0_d_bits_data    = tl_out_d_bits_data;
   assign tl_in0_d_bits_corrupt = tl_out_d_bits_corrupt;
   assign tl_in1_d_bits_opcode  = tl_out_d_bits_opcode;
   assign tl_in1_d_bits_param   = tl_out_d_bits_param;
   assign tl_in1_d_bits_size    = tl_out_d_bits_size;
   assign tl_in1_d_bits_source  = tl_out_d_bits_source[SOURCE_BITS-1:0];
   assign tl_in1_d_bits_sink    = tl_out_d_bits_sink;
   assign tl_in1_d_bits_denied  = tl_out_d_bits_denied;
   assign tl_in1_d_bits_data    = tl_out_d_bits_data;
   assign tl_in1_d_bits_corrupt = tl_out_d_bits_corrupt;

   tl_inflight_counter #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_inflight0 (
      .clock      (clock),
      .reset      (reset),
      .inc        (a_fire_n[0]),
      .dec        (d_fire_n[0]),
      .at_limit_c (at_limit[0])
   );

   tl_inflight_counter #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_inflight1 (
      .clock      (clock),
      .reset      (reset),
      .inc        (a_fire_n[1]),
      .dec        (d_fire_n[1]),
      .at_limit_c (at_limit[1])
   );

endmodule
